// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table scan engine.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_POS = 1'b0;  // masks list maxterms
    localparam logic MODE_SOP = 1'b1;  // masks list minterms

    // Number of truth-table rows for n input variables.
    function automatic int rows(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/tt_scan_engine_row_eval.sv
// Combinational evaluation of every function at one truth-table row.
// A maxterm mask gives f = 0 on listed rows; a minterm mask gives f = 1 on listed rows.
module tt_row_eval
    import tt_pkg::*;
#(
    parameter int N_VARS  = 3,
    parameter int N_FUNCS = 5
) (
    input  logic [N_FUNCS*rows(N_VARS)-1:0] mask,
    input  logic                            mode,
    input  logic [N_VARS-1:0]               row,
    output logic [N_FUNCS-1:0]              f
);

    localparam int ROWS = rows(N_VARS);

    genvar gi;
    generate
        for (gi = 0; gi < N_FUNCS; gi++) begin : g_func
            logic [ROWS-1:0] mask_k;
            // Pick function gi's mask bit for this row and apply the list polarity.
            always_comb begin
                mask_k = mask[gi*ROWS +: ROWS];
                f[gi]  = (mode == MODE_SOP) ? mask_k[row] : ~mask_k[row];
            end
        end
    endgenerate

endmodule

// File: rtl/tt_scan_engine.sv
// Sequential truth-table generator: streams one row per ready/valid handshake.
// Optional feature macro: TT_ZERO_COUNT_EN adds per-function zero counters (zero_cnt).
module tt_scan_engine
    import tt_pkg::*;
#(
    parameter int N_VARS  = 3,
    parameter int N_FUNCS = 5
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            abort,
    input  logic                            mode,
    input  logic [N_FUNCS*rows(N_VARS)-1:0] fn_mask,
    input  logic                            out_ready,
    output logic                            out_valid,
    output logic [N_VARS-1:0]               row_idx,
    output logic [N_FUNCS-1:0]              func_out,
    output logic                            busy,
`ifdef TT_ZERO_COUNT_EN
    output logic [N_FUNCS*(N_VARS+1)-1:0]   zero_cnt,
`endif
    output logic                            done
);

    localparam int              ROWS     = rows(N_VARS);
    localparam logic [N_VARS-1:0] LAST_ROW = N_VARS'(ROWS - 1);

    state_t                     state_reg, state_next;
    logic [N_FUNCS*ROWS-1:0]    mask_snap_reg;
    logic                       mode_snap_reg;
    logic [N_VARS-1:0]          row_reg;
    logic [N_FUNCS-1:0]         func_reg;

    logic                       load;      // start honoured this cycle
    logic                       step;      // row accepted and not cancelled
    logic [N_FUNCS*ROWS-1:0]    eval_mask;
    logic                       eval_mode;
    logic [N_VARS-1:0]          eval_row;
    logic [N_FUNCS-1:0]         eval_f;

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        step       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SCAN;
                    load       = ~abort;
                end
            end
            SCAN: begin
                if (out_ready) begin
                    step = ~abort;
                    if (row_reg == LAST_ROW) state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort) state_next = IDLE;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // On start evaluate row 0 from the live inputs; afterwards use the snapshot.
    always_comb begin
        eval_mask = load ? fn_mask : mask_snap_reg;
        eval_mode = load ? mode    : mode_snap_reg;
        eval_row  = load ? '0      : row_reg + N_VARS'(1);
    end

    tt_row_eval #(
        .N_VARS  (N_VARS),
        .N_FUNCS (N_FUNCS)
    ) u_row_eval (
        .mask (eval_mask),
        .mode (eval_mode),
        .row  (eval_row),
        .f    (eval_f)
    );

    // Snapshot, row counter and registered function outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_snap_reg <= '0;
            mode_snap_reg <= MODE_POS;
            row_reg       <= '0;
            func_reg      <= '0;
        end else if (load) begin
            mask_snap_reg <= fn_mask;
            mode_snap_reg <= mode;
            row_reg       <= '0;
            func_reg      <= eval_f;
        end else if (abort) begin
            row_reg       <= '0;
        end else if (step) begin
            // The counter wraps to 0 naturally after the last row.
            row_reg       <= eval_row;
            func_reg      <= eval_f;
        end
    end

    assign out_valid = (state_reg == SCAN);
    assign busy      = (state_reg == SCAN);
    assign done      = (state_reg == DONE);
    assign row_idx   = row_reg;
    assign func_out  = func_reg;

`ifdef TT_ZERO_COUNT_EN
    localparam int ZW = N_VARS + 1;

    genvar gi;
    generate
        for (gi = 0; gi < N_FUNCS; gi++) begin : g_zero
            logic [ZW-1:0] zc_reg;
            // Count accepted rows where this function is 0; held after done or abort.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)                     zc_reg <= '0;
                else if (load)                  zc_reg <= '0;
                else if (step && !func_reg[gi]) zc_reg <= zc_reg + ZW'(1);
            end
            assign zero_cnt[gi*ZW +: ZW] = zc_reg;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_tt_scan_engine.sv
// Self-checking bench for tt_scan_engine: table-driven scans plus corner-case sequences.
module tb_tt_scan_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] fn_mask = '0;
    logic        out_ready = 1'b1;
    logic        out_valid;
    logic [2:0]  row_idx;
    logic [1:0]  func_out;
    logic        busy;
    logic        done;
`ifdef TT_ZERO_COUNT_EN
    logic [7:0]  zero_cnt;
    logic [1:0]  zc1;
    logic [8:0]  zc8;
`endif

    // Small-parameter instances for the 1- and 8-variable boundaries.
    logic          s_start = 1'b0;
    logic          d1_valid, d1_busy, d1_done, d8_valid, d8_busy, d8_done;
    logic [0:0]    d1_row, d1_func, d8_func;
    logic [7:0]    d8_row;
    logic [255:0]  d8_mask;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tt_scan_engine #(.N_VARS(3), .N_FUNCS(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .fn_mask(fn_mask), .out_ready(out_ready), .out_valid(out_valid),
        .row_idx(row_idx), .func_out(func_out), .busy(busy),
`ifdef TT_ZERO_COUNT_EN
        .zero_cnt(zero_cnt),
`endif
        .done(done));

    tt_scan_engine #(.N_VARS(1), .N_FUNCS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(s_start), .abort(1'b0), .mode(1'b1),
        .fn_mask(2'b10), .out_ready(1'b1), .out_valid(d1_valid),
        .row_idx(d1_row), .func_out(d1_func), .busy(d1_busy),
`ifdef TT_ZERO_COUNT_EN
        .zero_cnt(zc1),
`endif
        .done(d1_done));

    tt_scan_engine #(.N_VARS(8), .N_FUNCS(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(s_start), .abort(1'b0), .mode(1'b1),
        .fn_mask(d8_mask), .out_ready(1'b1), .out_valid(d8_valid),
        .row_idx(d8_row), .func_out(d8_func), .busy(d8_busy),
`ifdef TT_ZERO_COUNT_EN
        .zero_cnt(zc8),
`endif
        .done(d8_done));

    assign d8_mask = {128{2'b10}};

    typedef struct {
        logic       mode;
        logic [7:0] m0, m1;   // masks for f0, f1
        logic [7:0] e0, e1;   // expected f0, f1 per row (bit r = row r)
        int         z0, z1;   // expected zero counts
    } vec_t;

    vec_t       vecs[4];
    logic [4:0] exp_q[$];     // {row, f1, f0}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Main-DUT output monitor: scoreboard, stall stability and done timing.
    logic       prev_stall = 1'b0;
    logic [2:0] prev_row;
    logic [1:0] prev_func;
    logic       last_acc = 1'b0;
    logic       seen_done = 1'b0;
    logic [4:0] exp_item;
    always @(negedge clk) begin
        if (last_acc || done) begin
            check("done_pulse", {31'd0, done}, {31'd0, last_acc});
            if (last_acc) check("valid_after_last", {30'd0, out_valid, busy}, 32'd0);
        end
        if (done) seen_done = 1'b1;
        if (prev_stall && out_valid) begin
            check("stall_row", {29'd0, row_idx}, {29'd0, prev_row});
            check("stall_func", {30'd0, func_out}, {30'd0, prev_func});
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_row", {29'd0, row_idx}, 32'hFFFF_FFFF);
            end else begin
                exp_item = exp_q.pop_front();
                $display("row %0d func %b expected row %0d func %b",
                         row_idx, func_out, exp_item[4:2], exp_item[1:0]);
                check("row_idx", {29'd0, row_idx}, {29'd0, exp_item[4:2]});
                check("func_out", {30'd0, func_out}, {30'd0, exp_item[1:0]});
            end
        end
        prev_stall = out_valid & ~out_ready;
        prev_row   = row_idx;
        prev_func  = func_out;
        last_acc   = out_valid & out_ready & (row_idx == 3'd7);
    end

    // Boundary-instance monitors: rows must count 0..ROWS-1 and f = row parity.
    int cnt1 = 0, cnt8 = 0;
    logic d1_seen = 1'b0, d8_seen = 1'b0;
    always @(negedge clk) begin
        if (d1_valid) begin
            check("n1_row", {31'd0, d1_row}, cnt1);
            check("n1_func", {31'd0, d1_func}, {31'd0, cnt1[0]});
            cnt1++;
        end
        if (d8_valid) begin
            check("n8_row", {24'd0, d8_row}, cnt8);
            check("n8_func", {31'd0, d8_func}, {31'd0, cnt8[0]});
            cnt8++;
        end
        if (d1_done) d1_seen = 1'b1;
        if (d8_done) d8_seen = 1'b1;
    end

    task automatic push_rows(input vec_t v, input int n);
        for (int r = 0; r < n; r++) exp_q.push_back({r[2:0], v.e1[r], v.e0[r]});
    endtask

    // One full scan; optional 1,0,0,1 ready pattern and mid-scan restart attempt.
    task automatic run_scan(input vec_t v, input bit toggle, input bit restart);
        logic [3:0] pat;
        bit ok;
        pat = 4'b1001;
        ok  = 1'b0;
        fn_mask   = {v.m1, v.m0};
        mode      = v.mode;
        out_ready = 1'b1;
        seen_done = 1'b0;
        push_rows(v, 8);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("valid_latency", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 300; i++) begin
            if (toggle) out_ready = pat[i % 4];
            if (restart) begin
                start = (i == 2);
                if (i == 2) begin
                    fn_mask = ~fn_mask;
                    mode    = ~mode;
                end
            end
            @(posedge clk); #1;
            if (seen_done && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
        check("scan_complete", {31'd0, ok}, 32'd1);
        exp_q.delete();
`ifdef TT_ZERO_COUNT_EN
        check("zero_cnt", {24'd0, zero_cnt}, {24'd0, v.z1[3:0], v.z0[3:0]});
`endif
        @(posedge clk); #1;
    endtask

    // Wait (bounded) for the main DUT to present a given row.
    task automatic wait_row(input logic [2:0] r, output bit found);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (out_valid && row_idx == r) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit found;
        vecs[0] = '{1'b0, 8'h0F, 8'hAA, 8'hF0, 8'h55, 4, 4};
        vecs[1] = '{1'b1, 8'h0F, 8'hAA, 8'h0F, 8'hAA, 4, 4};
        vecs[2] = '{1'b0, 8'h00, 8'hFF, 8'hFF, 8'h00, 0, 8};
        vecs[3] = '{1'b1, 8'h3C, 8'h81, 8'h3C, 8'h81, 4, 6};

        #3;
        check("reset_outputs", {26'd0, out_valid, row_idx, func_out, busy, done}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) run_scan(vecs[i], 1'b0, 1'b0);
        run_scan(vecs[0], 1'b1, 1'b0);
        run_scan(vecs[3], 1'b1, 1'b1);

        // Abort at row 3: no done, idle next cycle, then a clean rescan.
        fn_mask = {vecs[0].m1, vecs[0].m0};
        mode    = vecs[0].mode;
        push_rows(vecs[0], 3);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_row(3'd3, found);
        check("abort_reach_row3", {31'd0, found}, 32'd1);
        out_ready = 1'b0;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        out_ready = 1'b1;
        check("abort_idle", {28'd0, out_valid, busy, done, 1'b0}, 32'd0);
        check("abort_row", {29'd0, row_idx}, 32'd0);
        check("abort_queue", exp_q.size(), 32'd0);
        repeat (3) @(posedge clk);
        #1 check("abort_no_done", {31'd0, done | busy}, 32'd0);
        run_scan(vecs[1], 1'b0, 1'b0);

        // Start and abort together in IDLE: abort wins.
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", {30'd0, out_valid, busy}, 32'd0);

        // Asynchronous reset at row 5.
        fn_mask = {vecs[2].m1, vecs[2].m0};
        mode    = vecs[2].mode;
        push_rows(vecs[2], 5);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_row(3'd5, found);
        check("reset_reach_row5", {31'd0, found}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("reset_midscan", {26'd0, out_valid, row_idx, func_out, busy, done}, 32'd0);
        check("reset_queue", exp_q.size(), 32'd0);
        exp_q.delete();
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("reset_stays_idle", {30'd0, out_valid, busy}, 32'd0);
        run_scan(vecs[2], 1'b0, 1'b0);

        // Boundary sizes: 2 and 256 rows.
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (d1_seen && d8_seen) break;
        end
        check("n1_rows", cnt1, 32'd2);
        check("n8_rows", cnt8, 32'd256);
        check("n1_n8_done", {30'd0, d1_seen, d8_seen}, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
